// File: rtl/slave_fifo2b_pkg.sv
// Definitions shared by the FX3 slave-FIFO Stream-IN and Stream-OUT blocks.
package slave_fifo2b_pkg;

    localparam int FX3_RD_LATENCY = 2;
    localparam int FX3_BUS_W      = 32;

    // 3 bits wide so the encodings line up with the Stream-IN writer
    typedef enum logic [2:0] {
        SO_IDLE       = 3'd0,
        SO_WAIT_FLAGD = 3'd1,
        SO_READ       = 3'd2,
        SO_DRAIN      = 3'd3
    } so_state_t;

endpackage

// File: rtl/slave_fifo2b_stream_out_fifo.sv
// First-word-fall-through FIFO buffering words read from the FX3 consumer socket.
module stream_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_100,
    input  logic                     reset_,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty; pointers wrap naturally
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr == rd_ptr);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_100) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/slave_fifo2b_stream_out.sv
// FX3 slave-FIFO Stream-OUT reader: issues SLRD#/SLOE#, realigns the read
// latency and hands words to FPGA logic through a valid/ready FIFO.
module slave_fifo2b_stream_out
    import slave_fifo2b_pkg::*;
#(
    parameter int RD_LATENCY = FX3_RD_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_100,
    input  logic                 reset_,
    input  logic                 stream_out_mode_selected,
    input  logic                 flagc_d,
    input  logic                 flagd_d,
    input  logic [FX3_BUS_W-1:0] data_in,
    output logic                 slrd_streamOUT_,
    output logic                 sloe_streamOUT_,
    output logic [FX3_BUS_W-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 reading,
    output logic                 waiting_enter_reading,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
    localparam int DW = $clog2(RD_LATENCY) + 1;

    so_state_t             state;
    so_state_t             next_state;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [DW-1:0]         drain_cnt;
    logic [AW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic                  slrd_nxt;
    logic                  sloe_nxt;

    function automatic logic [CW-1:0] popcount(input logic [RD_LATENCY-1:0] v);
        popcount = '0;
        for (int i = 0; i < RD_LATENCY; i++) popcount = popcount + CW'(v[i]);
    endfunction

    // The strobe currently on SLRD# is also owed a slot, hence the extra term
    assign credit_ok = (CW'(fifo_count) + popcount(rd_pipe) + CW'(!slrd_streamOUT_))
                       < CW'(FIFO_DEPTH - 1);

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) state <= SO_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SO_IDLE:       if (stream_out_mode_selected && flagc_d) next_state = SO_WAIT_FLAGD;
            SO_WAIT_FLAGD: begin
                if (!stream_out_mode_selected) next_state = SO_IDLE;
                else if (flagd_d)              next_state = SO_READ;
            end
            SO_READ:       if (!flagd_d || !stream_out_mode_selected) next_state = SO_DRAIN;
            SO_DRAIN:      if (drain_cnt == DW'(RD_LATENCY - 1)) next_state = SO_IDLE;
            default:       next_state = SO_IDLE;
        endcase
    end

    always_comb begin
        sloe_nxt              = (state == SO_IDLE);
        slrd_nxt              = !((state == SO_READ) && flagd_d &&
                                  stream_out_mode_selected && credit_ok);
        reading               = (state == SO_READ);
        waiting_enter_reading = (state == SO_WAIT_FLAGD);
    end

    // rd_pipe marks which cycles' data_in answers an earlier SLRD# strobe
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            slrd_streamOUT_ <= 1'b1;
            sloe_streamOUT_ <= 1'b1;
            rd_pipe         <= '0;
            drain_cnt       <= '0;
        end else begin
            slrd_streamOUT_ <= slrd_nxt;
            sloe_streamOUT_ <= sloe_nxt;
            rd_pipe         <= (rd_pipe << 1) | RD_LATENCY'(!slrd_streamOUT_);
            drain_cnt       <= (state == SO_DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    assign push           = rd_pipe[RD_LATENCY-1];
    assign data_out_valid = !fifo_empty;
    assign pop            = data_out_valid && data_out_ready;

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_)                          overflow <= 1'b0;
        else if (push && fifo_full && !pop)   overflow <= 1'b1;
    end

    stream_out_fifo #(
        .WIDTH (FX3_BUS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100   (clk_100),
        .reset_    (reset_),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (data_out),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_slave_fifo2b_stream_out.sv
// Directed bench for the Stream-OUT reader with an FX3 responder and a queue model.
module tb_slave_fifo2b_stream_out;

    localparam int DEPTH = 8;

    logic        clk_100 = 1'b0;
    logic        reset_;
    logic        mode;
    logic        flagc_d;
    logic        flagd_d;
    logic [31:0] data_in;
    logic        slrd_;
    logic        sloe_;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        reading;
    logic        waiting;
    logic        overflow;

    always #5 clk_100 = ~clk_100;

    slave_fifo2b_stream_out dut (
        .clk_100                  (clk_100),
        .reset_                   (reset_),
        .stream_out_mode_selected (mode),
        .flagc_d                  (flagc_d),
        .flagd_d                  (flagd_d),
        .data_in                  (data_in),
        .slrd_streamOUT_          (slrd_),
        .sloe_streamOUT_          (sloe_),
        .data_out                 (data_out),
        .data_out_valid           (data_out_valid),
        .data_out_ready           (data_out_ready),
        .reading                  (reading),
        .waiting_enter_reading    (waiting),
        .overflow                 (overflow)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          slrd_cnt = 0;
    int          pop_cnt  = 0;
    logic [31:0] fx3_n    = 32'd0;
    logic [1:0]  hist;
    logic [31:0] mq[$];
    logic        model_ovf = 1'b0;
    logic [31:0] last_pop  = 32'd0;
    bit          chk_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FX3 responder: the word for a strobe sampled low appears two cycles later
    assign data_in = 32'h1000 + fx3_n;
    always @(posedge clk_100 or negedge reset_) begin
        if (!reset_) hist <= 2'b00;
        else         hist <= {hist[0], ~slrd_};
    end
    always @(posedge clk_100) if (hist[1]) fx3_n <= fx3_n + 1;
    always @(posedge clk_100) if (!slrd_) slrd_cnt++;

    // Reference buffer: a plain queue of delivered words, DEPTH entries max
    always @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            mq.delete();
            model_ovf = 1'b0;
        end else begin
            bit full_b;
            bit pop_m;
            full_b = (mq.size() == DEPTH);
            pop_m  = (mq.size() != 0) && data_out_ready;
            if (pop_m) begin
                last_pop = mq.pop_front();
                pop_cnt++;
            end
            if (hist[1]) begin
                if (!full_b || pop_m) mq.push_back(data_in);
                else                  model_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk_100) begin
        if (chk_en) begin
            check("valid", data_out_valid, mq.size() != 0);
            if (mq.size() != 0) check("data", data_out, mq[0]);
            check("overflow", overflow, model_ovf);
            if (!slrd_) check("sloe_with_slrd", sloe_, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t, required end before 100000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int k_rd, k_v, k_fall, k_oe, k_des, base_rd, base_pop, n, issued, pulses_at;
        logic [31:0] first_word;

        reset_ = 1'b0; mode = 1'b0; flagc_d = 1'b0; flagd_d = 1'b0; data_out_ready = 1'b1;
        #12;
        check("rst_slrd", slrd_, 1'b1);
        check("rst_sloe", sloe_, 1'b1);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_data", data_out, 32'h0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_reading", reading, 1'b0);
        check("rst_waiting", waiting, 1'b0);
        @(negedge clk_100);
        reset_ = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk_100);
        check("idle_sloe", sloe_, 1'b1);

        // Basic burst: flagd high for 20 sampled edges
        base_rd = slrd_cnt; base_pop = pop_cnt;
        k_rd = 0; k_v = 0; k_fall = 0; k_oe = 0; first_word = 32'h0;
        mode = 1'b1; flagc_d = 1'b1; flagd_d = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_100);
            if (k_rd == 0 && !slrd_) k_rd = k;
            if (k_v == 0 && data_out_valid) begin k_v = k; first_word = data_out; end
            if (k_fall == 0 && k_rd != 0 && !reading) k_fall = k;
            if (k_oe == 0 && k_fall != 0 && sloe_) k_oe = k;
            if (k == 20) flagd_d = 1'b0;
            if (k == 21) begin mode = 1'b0; flagc_d = 1'b0; end
        end
        check("burst_first_slrd", k_rd, 3);
        check("burst_valid_lat", k_v - k_rd, 3);
        check("burst_first_word", first_word, 32'h1000);
        check("burst_pulses", slrd_cnt - base_rd, 18);
        check("burst_words", pop_cnt - base_pop, 18);
        check("burst_last_word", last_pop, 32'h1011);
        check("burst_read_end", k_fall, 21);
        // two DRAIN cycles plus one for the registered SLOE#
        check("burst_drain", k_oe - k_fall, 3);

        // Backpressure: consumer stalled for the whole burst
        base_rd = slrd_cnt; base_pop = pop_cnt;
        data_out_ready = 1'b0; mode = 1'b1; flagc_d = 1'b1; flagd_d = 1'b1;
        repeat (30) @(negedge clk_100);
        n = slrd_cnt - base_rd;
        check("bp_pulses_max", (n > 0) && (n <= DEPTH - 1), 1'b1);
        check("bp_still_read", reading, 1'b1);
        check("bp_ovf", overflow, 1'b0);
        data_out_ready = 1'b1;
        repeat (10) @(negedge clk_100);
        flagd_d = 1'b0; mode = 1'b0; flagc_d = 1'b0;
        repeat (15) @(negedge clk_100);
        check("bp_resumed", (slrd_cnt - base_rd) > n, 1'b1);
        check("bp_words", pop_cnt - base_pop, slrd_cnt - base_rd);
        check("bp_idle", {reading, waiting, sloe_}, 3'b001);

        // Flag drop while reads are in flight
        base_rd = slrd_cnt; base_pop = pop_cnt;
        mode = 1'b1; flagc_d = 1'b1; flagd_d = 1'b1;
        repeat (8) @(negedge clk_100);
        check("fd_streaming", slrd_, 1'b0);
        pulses_at = slrd_cnt - base_rd + (slrd_ ? 0 : 1);
        check("fd_pulses", pulses_at, 6);
        flagd_d = 1'b0;
        k_fall = 0; k_oe = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_100);
            if (k == 1) begin
                check("fd_slrd_off", slrd_, 1'b1);
                mode = 1'b0; flagc_d = 1'b0;
            end
            if (k_fall == 0 && !reading) k_fall = k;
            if (k_oe == 0 && k_fall != 0 && sloe_) k_oe = k;
        end
        check("fd_no_more", slrd_cnt - base_rd, pulses_at);
        check("fd_words", pop_cnt - base_pop, pulses_at);
        check("fd_read_end", k_fall, 1);
        check("fd_drain", k_oe - k_fall, 3);

        // Mode deselect once the sixth word has been requested
        base_rd = slrd_cnt; base_pop = pop_cnt; k_des = 0;
        mode = 1'b1; flagc_d = 1'b1; flagd_d = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_100);
            issued = slrd_cnt - base_rd + (slrd_ ? 0 : 1);
            if (k_des != 0 && k == k_des + 1) check("des_slrd_next", slrd_, 1'b1);
            if (k_des == 0 && issued == 6) begin mode = 1'b0; k_des = k; end
        end
        check("des_when", k_des, 8);
        check("des_pulses", slrd_cnt - base_rd, 6);
        check("des_words", pop_cnt - base_pop, 6);
        check("des_idle", {reading, waiting, sloe_}, 3'b001);
        flagc_d = 1'b0; flagd_d = 1'b0;

        // Asynchronous reset mid-burst with words buffered
        data_out_ready = 1'b0; mode = 1'b1; flagc_d = 1'b1; flagd_d = 1'b1;
        repeat (12) @(negedge clk_100);
        check("mid_buffered", data_out_valid, 1'b1);
        @(posedge clk_100);
        #3 reset_ = 1'b0;
        #1;
        check("arst_slrd", slrd_, 1'b1);
        check("arst_sloe", sloe_, 1'b1);
        check("arst_valid", data_out_valid, 1'b0);
        check("arst_data", data_out, 32'h0);
        mode = 1'b0; flagc_d = 1'b0; flagd_d = 1'b0; data_out_ready = 1'b1;
        @(negedge clk_100);
        reset_ = 1'b1;
        repeat (3) @(negedge clk_100);
        check("arst_after", {reading, waiting, sloe_, data_out_valid}, 4'b0010);

        // Overflow forced by bypassing the credit limit
        base_pop = pop_cnt;
        data_out_ready = 1'b0; mode = 1'b1; flagc_d = 1'b1; flagd_d = 1'b1;
        force dut.credit_ok = 1'b1;
        repeat (20) @(negedge clk_100);
        check("ovf_set", overflow, 1'b1);
        release dut.credit_ok;
        flagd_d = 1'b0; mode = 1'b0; flagc_d = 1'b0;
        repeat (4) @(negedge clk_100);
        data_out_ready = 1'b1;
        repeat (15) @(negedge clk_100);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_kept_words", pop_cnt - base_pop, DEPTH);
        check("ovf_drained", data_out_valid, 1'b0);
        @(posedge clk_100);
        #3 reset_ = 1'b0;
        #1;
        check("ovf_cleared", overflow, 1'b0);
        @(negedge clk_100);
        reset_ = 1'b1;
        repeat (2) @(negedge clk_100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
